// File: rtl/risc16_mem_unit_if.sv
// Instruction and data port bundle for the risc16 memory unit.
// Master is the core side, slave is the memory side.
interface risc16_mem_unit_if #(
  parameter int WORD_LENGTH = 16,
  parameter int ADDR_WIDTH  = 16
) ();
  logic                   i_req;
  logic [ADDR_WIDTH-1:0]  i_addr;
  logic                   i_ready;
  logic                   i_rvalid;
  logic [WORD_LENGTH-1:0] i_rdata;
  logic                   d_req;
  logic                   d_we;
  logic [ADDR_WIDTH-1:0]  d_addr;
  logic [WORD_LENGTH-1:0] d_wdata;
  logic                   d_ready;
  logic                   d_rvalid;
  logic [WORD_LENGTH-1:0] d_rdata;

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    input  i_ready, i_rvalid, i_rdata,
    input  d_ready, d_rvalid, d_rdata
  );

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    output i_ready, i_rvalid, i_rdata,
    output d_ready, d_rvalid, d_rdata
  );
endinterface

// File: rtl/risc16_mem_unit.sv
// Single-ported word memory shared by instruction and data ports,
// with round-robin conflict arbitration and a sweep-clear engine.
module risc16_mem_unit #(
  parameter int WORD_LENGTH  = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              clr_busy,
  risc16_mem_unit_if.slave  bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    prio_i;
  logic                    conflict;
  logic                    rd_go;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [WORD_LENGTH-1:0]  mem [2**ADDR_WIDTH];

  logic [READ_LATENCY-1:0] pv;
  logic [READ_LATENCY-1:0] pp;
  logic [WORD_LENGTH-1:0]  pd [READ_LATENCY];
  logic [WORD_LENGTH-1:0]  i_hold;
  logic [WORD_LENGTH-1:0]  d_hold;

  always_comb begin
    state_nx    = state;
    conflict    = 1'b0;
    bus.i_ready = 1'b0;
    bus.d_ready = 1'b0;
    unique case (state)
      IDLE: begin
        conflict    = bus.i_req & bus.d_req;
        bus.i_ready = bus.i_req & (~bus.d_req | prio_i);
        bus.d_ready = bus.d_req & (~bus.i_req | ~prio_i);
        if (clr_start)
          state_nx = CLEAR;
      end
      CLEAR: begin
        if (&cnt)
          state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      prio_i <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == CLEAR)
        cnt <= cnt + ADDR_WIDTH'(1);
      if (conflict)
        prio_i <= ~prio_i;
    end
  end

  assign clr_busy = (state == CLEAR);
  assign rd_go    = bus.i_ready | (bus.d_ready & ~bus.d_we);
  assign rd_addr  = bus.i_ready ? bus.i_addr : bus.d_addr;

  // Array has no reset; only the sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[cnt] <= '0;
      else if (bus.d_ready & bus.d_we)
        mem[bus.d_addr] <= bus.d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv[0] <= rd_go;
      for (int k = 1; k < READ_LATENCY; k++)
        pv[k] <= pv[k-1];
    end
  end

  always_ff @(posedge clk) begin
    pp[0] <= bus.i_ready;
    pd[0] <= mem[rd_addr];
    for (int k = 1; k < READ_LATENCY; k++) begin
      pp[k] <= pp[k-1];
      pd[k] <= pd[k-1];
    end
  end

  assign bus.i_rvalid = pv[READ_LATENCY-1] & pp[READ_LATENCY-1];
  assign bus.d_rvalid = pv[READ_LATENCY-1] & ~pp[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      if (bus.i_rvalid)
        i_hold <= pd[READ_LATENCY-1];
      if (bus.d_rvalid)
        d_hold <= pd[READ_LATENCY-1];
    end
  end

  assign bus.i_rdata = bus.i_rvalid ? pd[READ_LATENCY-1] : i_hold;
  assign bus.d_rdata = bus.d_rvalid ? pd[READ_LATENCY-1] : d_hold;

endmodule

// File: tb/tb_risc16_mem_unit.sv
// Directed bench for risc16_mem_unit: a 16-word latency-1 instance
// and a 256-word latency-3 instance.
module tb_risc16_mem_unit;

  logic clk;
  logic rst;
  logic a_clr_start;
  logic a_clr_busy;
  logic b_clr_start;
  logic b_clr_busy;
  int   total;
  int   bad;

  risc16_mem_unit_if #(.WORD_LENGTH(16), .ADDR_WIDTH(4)) ba ();
  risc16_mem_unit_if #(.WORD_LENGTH(16), .ADDR_WIDTH(8)) bb ();

  risc16_mem_unit #(
    .WORD_LENGTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .clr_start(a_clr_start), .clr_busy(a_clr_busy),
    .bus(ba)
  );

  risc16_mem_unit #(
    .WORD_LENGTH(16), .ADDR_WIDTH(8), .READ_LATENCY(3)
  ) u_b (
    .clk(clk), .rst(rst),
    .clr_start(b_clr_start), .clr_busy(b_clr_busy),
    .bus(bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_wr(input logic [3:0] ad, input logic [15:0] dt);
    ba.d_req   = 1'b1;
    ba.d_we    = 1'b1;
    ba.d_addr  = ad;
    ba.d_wdata = dt;
    tick();
    ba.d_req = 1'b0;
    ba.d_we  = 1'b0;
  endtask

  task automatic a_rd(input logic [3:0] ad,
                      input logic [15:0] exp,
                      input string tag);
    ba.d_req  = 1'b1;
    ba.d_we   = 1'b0;
    ba.d_addr = ad;
    tick();
    ba.d_req = 1'b0;
    chk({tag, "_v"}, ba.d_rvalid, 1);
    chk(tag, ba.d_rdata, exp);
  endtask

  initial begin
    int n;
    int rbad;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    a_clr_start = 1'b0;
    b_clr_start = 1'b0;
    ba.i_req = 1'b0; ba.i_addr = '0;
    ba.d_req = 1'b0; ba.d_we = 1'b0;
    ba.d_addr = '0; ba.d_wdata = '0;
    bb.i_req = 1'b0; bb.i_addr = '0;
    bb.d_req = 1'b0; bb.d_we = 1'b0;
    bb.d_addr = '0; bb.d_wdata = '0;
    repeat (3) tick();
    chk("rst_busy", a_clr_busy, 0);
    chk("rst_a_irv", ba.i_rvalid, 0);
    chk("rst_a_drv", ba.d_rvalid, 0);
    chk("rst_a_idata", ba.i_rdata, 0);
    chk("rst_b_ddata", bb.d_rdata, 0);
    rst = 1'b0;
    tick();

    // write then latency-3 read on instance b
    bb.d_req = 1'b1; bb.d_we = 1'b1;
    bb.d_addr = 8'h10; bb.d_wdata = 16'h1234;
    #1 chk("b_wr_ready", bb.d_ready, 1);
    tick();
    bb.d_req = 1'b0; bb.d_we = 1'b0;
    bb.i_req = 1'b1; bb.i_addr = 8'h10;
    #1 chk("b_i_ready", bb.i_ready, 1);
    tick();
    bb.i_req = 1'b0;
    chk("b_lat1", bb.i_rvalid, 0);
    tick();
    chk("b_lat2", bb.i_rvalid, 0);
    chk("b_wr_no_rv", bb.d_rvalid, 0);
    tick();
    chk("b_lat3", bb.i_rvalid, 1);
    chk("b_rdata", bb.i_rdata, 16'h1234);
    tick();
    chk("b_lat4", bb.i_rvalid, 0);
    chk("b_hold", bb.i_rdata, 16'h1234);

    // conflict arbitration on instance a
    a_wr(4'd2, 16'h2222);
    a_wr(4'd3, 16'h3333);
    a_wr(4'd4, 16'h4444);
    a_wr(4'd5, 16'h5555);
    ba.i_req = 1'b1; ba.i_addr = 4'd2;
    ba.d_req = 1'b1; ba.d_we = 1'b0; ba.d_addr = 4'd3;
    #1;
    chk("arb1_d", ba.d_ready, 1);
    chk("arb1_i", ba.i_ready, 0);
    tick();
    chk("arb1_rv", ba.d_rvalid, 1);
    chk("arb1_rd", ba.d_rdata, 16'h3333);
    chk("arb1_irv", ba.i_rvalid, 0);
    ba.d_addr = 4'd4;
    #1;
    chk("arb2_i", ba.i_ready, 1);
    chk("arb2_d", ba.d_ready, 0);
    tick();
    chk("arb2_rv", ba.i_rvalid, 1);
    chk("arb2_rd", ba.i_rdata, 16'h2222);
    chk("arb2_drv", ba.d_rvalid, 0);
    ba.i_addr = 4'd5;
    #1 chk("arb3_d", ba.d_ready, 1);
    tick();
    chk("arb3_rv", ba.d_rvalid, 1);
    chk("arb3_rd", ba.d_rdata, 16'h4444);
    #1 chk("arb4_i", ba.i_ready, 1);
    tick();
    ba.i_req = 1'b0; ba.d_req = 1'b0;
    chk("arb4_rv", ba.i_rvalid, 1);
    chk("arb4_rd", ba.i_rdata, 16'h5555);
    chk("arb4_drv", ba.d_rvalid, 0);
    tick();
    chk("arb_end_rv", ba.i_rvalid | ba.d_rvalid, 0);
    chk("arb_hold", ba.d_rdata, 16'h4444);

    // back-to-back reads
    for (int k = 0; k < 8; k++)
      a_wr(4'(k), 16'hA000 + 16'(k));
    for (int k = 0; k < 8; k++) begin
      ba.d_req = 1'b1; ba.d_we = 1'b0; ba.d_addr = 4'(k);
      tick();
      chk($sformatf("b2b_v%0d", k), ba.d_rvalid, 1);
      chk($sformatf("b2b_d%0d", k), ba.d_rdata, 16'hA000 + k);
    end
    ba.d_req = 1'b0;
    tick();
    chk("b2b_end", ba.d_rvalid, 0);

    // full sweep clear with read granted on the start cycle
    for (int k = 0; k < 16; k++)
      a_wr(4'(k), 16'hFFFF);
    a_clr_start = 1'b1;
    ba.d_req = 1'b1; ba.d_we = 1'b0; ba.d_addr = 4'd6;
    #1 chk("clr_grant", ba.d_ready, 1);
    tick();
    a_clr_start = 1'b0;
    chk("clr_rd_v", ba.d_rvalid, 1);
    chk("clr_rd_d", ba.d_rdata, 16'hFFFF);
    n = 0;
    rbad = 0;
    ba.i_req = 1'b1;
    ba.d_req = 1'b1; ba.d_we = 1'b1; ba.d_wdata = 16'h5A5A;
    for (int j = 0; j < 40; j++) begin
      if (!a_clr_busy) break;
      n++;
      a_clr_start = (j == 3);
      #1;
      if (ba.i_ready | ba.d_ready) rbad++;
      tick();
    end
    ba.i_req = 1'b0; ba.d_req = 1'b0; ba.d_we = 1'b0;
    a_clr_start = 1'b0;
    chk("clr_len", n, 16);
    chk("clr_ready", rbad, 0);
    tick();
    chk("clr_done", a_clr_busy, 0);
    for (int k = 0; k < 16; k++)
      a_rd(4'(k), 16'h0000, $sformatf("clr_rd%0d", k));

    // reset in the middle of a sweep
    for (int k = 0; k < 16; k++)
      a_wr(4'(k), 16'hFFFF);
    a_clr_start = 1'b1;
    tick();
    a_clr_start = 1'b0;
    repeat (5) tick();
    chk("abort_busy", a_clr_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_idle", a_clr_busy, 0);
    chk("abort_rdata", ba.d_rdata, 0);
    for (int k = 0; k < 16; k++)
      a_rd(4'(k), (k < 5) ? 16'h0000 : 16'hFFFF,
           $sformatf("abort_rd%0d", k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc16_mem_unit.md
RISC16_MEM_UNIT -- requirements
Module: risc16_mem_unit

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16; the array depth is 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal range 1..4, giving the grant-to-rvalid delay in cycles.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 clr_start  in  1  one-cycle pulse that starts a sweep clear of the whole array.
REQ-007 clr_busy  out  1  high while the sweep clear runs.
REQ-008 i_req  in  1  instruction-port read request.
REQ-009 i_addr  in  ADDR_WIDTH  instruction-port word address.
REQ-010 i_ready  out  1  instruction-port grant; combinational from the requests, arbiter state and FSM state.
REQ-011 i_rvalid  out  1  instruction read data valid.
REQ-012 i_rdata  out  WORD_LENGTH  instruction read data.
REQ-013 d_req  in  1  data-port request.
REQ-014 d_we  in  1  data-port write (1) or read (0).
REQ-015 d_addr  in  ADDR_WIDTH  data-port word address.
REQ-016 d_wdata  in  WORD_LENGTH  data-port write data.
REQ-017 d_ready  out  1  data-port grant.
REQ-018 d_rvalid  out  1  data read data valid.
REQ-019 d_rdata  out  WORD_LENGTH  data read data.

Function
REQ-020 SHALL hold one single-ported array, with at most one access granted per cycle; a transfer occurs when req and ready are both high.
REQ-021 SHALL grant the only requester when exactly one port requests in state IDLE.
REQ-022 On a conflict (i_req and d_req both high), SHALL grant the port that lost the previous conflict; the priority pointer SHALL toggle only on conflict cycles.
REQ-023 An ungranted requester SHALL hold req and its address/data stable until it is granted.
REQ-024 A granted write SHALL update the array at the same clock edge; it SHALL produce no rvalid.
REQ-025 A granted read SHALL assert that port's rvalid for exactly one cycle, READ_LATENCY cycles after the grant edge.
REQ-026 The rdata of a granted read SHALL be the array value at the grant edge, including any write committed at an earlier edge.
REQ-027 Reads SHALL be fully pipelined, allowing back-to-back grants every cycle; return order per port SHALL equal grant order.
REQ-028 rdata SHALL hold its last value when rvalid is low.
REQ-029 SHALL use a two-state FSM, IDLE and CLEAR.
REQ-030 IDLE -> CLEAR on clr_start; in CLEAR, a counter SHALL write 0 to address 0, 1, ... 2^ADDR_WIDTH-1, one word per cycle.
REQ-031 CLEAR -> IDLE in the cycle after the last address is written; the counter SHALL wrap to 0.
REQ-032 In CLEAR, i_ready and d_ready SHALL be 0 and clr_start SHALL be ignored.
REQ-033 Reads already in the pipeline when CLEAR is entered SHALL still complete with their captured data.
REQ-034 clr_busy SHALL equal (state == CLEAR).
REQ-035 The array SHALL accept a clr_start pulse coincident with a grant: the grant completes in that cycle and CLEAR starts on the next cycle.

Reset
REQ-036 rst SHALL force the FSM to IDLE, the clear counter to 0 and the priority pointer to data-port-first, and SHALL zero all rvalid pipeline stages.
REQ-037 rst SHALL drive i_rdata and d_rdata to 0.
REQ-038 rst SHALL leave array contents unchanged; zeroing the array is done only through clr_start.
REQ-039 rst during CLEAR SHALL abort the sweep, leaving a partially cleared array.
REQ-040 rst has priority over every request and clr_start in the same cycle.

Verification
REQ-041 Bench: d write 0x1234 @0x0010, then i read @0x0010 with READ_LATENCY=3 -> i_rvalid three cycles after the grant, i_rdata=0x1234.
REQ-042 Bench: i_req and d_req held high for 4 cycles -> grants D,I,D,I; each port receives exactly 2 rvalids in order.
REQ-043 Bench: ADDR_WIDTH=4, fill all 16 words with 0xFFFF, pulse clr_start -> clr_busy high 16 cycles, readies low, then reading any address returns 0.
REQ-044 Bench: rst asserted on cycle 5 of the clear (ADDR_WIDTH=4) -> clr_busy 0 next cycle; addresses 0..4 read 0, addresses 5..15 read 0xFFFF.
REQ-045 Bench: back-to-back d reads @0..7, READ_LATENCY=1 -> d_rvalid high for 8 consecutive cycles, data matches the array contents.
REQ-046 Bench: read granted on the same cycle as clr_start -> its rvalid still appears with the pre-clear data.
